abnormality_event_logger: RTL and testbench

Timestamped event recorder sitting directly downstream of the healthcare system top level. It watches the 6-bit abnormality vector and the 3-bit warning level, and detects each new abnormality or warning escalation. Every detected event is stored as a timestamped record in a small FIFO. Records drain through a valid/ready handshake to the nurse-station link, and a saturating counter tracks events dropped on overflow.

---
 rtl/abnormality_event_logger_if.sv | 27 ++
 rtl/abnormality_event_logger.sv | 108 ++++++++++
 tb/tb_abnormality_event_logger.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/abnormality_event_logger_if.sv
// Event record stream: head record plus valid/ready handshake.
// master = logger (valid, timestamp, warning, vector out; ready in).
interface abnormality_event_logger_if #(
  parameter int TS_WIDTH = 8
);
  logic                eventValid;
  logic                eventReady;
  logic [TS_WIDTH-1:0] eventTimestamp;
  logic [2:0]          eventWarning;
  logic [5:0]          eventVector;

  modport master (
    output eventValid,
    output eventTimestamp,
    output eventWarning,
    output eventVector,
    input  eventReady
  );

  modport slave (
    input  eventValid,
    input  eventTimestamp,
    input  eventWarning,
    input  eventVector,
    output eventReady
  );
endinterface

// File: rtl/abnormality_event_logger.sv
// Timestamped abnormality/warning-escalation recorder with FWFT FIFO.
// Ports: clock, resetN, abnormalityVector/Warning, clearOverflow, evt stream, eventCount, overflow(Count).
module abnormality_event_logger #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [5:0]               abnormalityVector,
  input  logic [2:0]               abnormalityWarning,
  input  logic                     clearOverflow,
  abnormality_event_logger_if.master evt,
  output logic [$clog2(DEPTH):0]   eventCount,
  output logic                     overflow,
  output logic [7:0]               overflowCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_WIDTH + 9;

  logic [RW-1:0]       r_mem [DEPTH];
  logic [AW:0]         r_wptr;
  logic [AW:0]         r_rptr;
  logic [RW-1:0]       r_head;
  logic [5:0]          r_prevVector;
  logic [2:0]          r_prevWarning;
  logic [TS_WIDTH-1:0] r_ts;
  logic                r_overflow;
  logic [7:0]          r_ovfCount;

  logic          w_empty;
  logic          w_full;
  logic          w_trigger;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [RW-1:0] w_rec;
  logic [AW:0]   w_rptrNxt;
  logic [AW:0]   w_wptrNxt;
  logic [RW-1:0] w_headNxt;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                   (r_wptr[AW] != r_rptr[AW]);

  assign w_trigger = (|(abnormalityVector & ~r_prevVector)) ||
                     (abnormalityWarning > r_prevWarning);

  assign w_pop  = !w_empty && evt.eventReady;
  assign w_push = w_trigger && (!w_full || w_pop);
  assign w_drop = w_trigger && w_full && !w_pop;
  assign w_rec  = {r_ts, abnormalityWarning, abnormalityVector};

  assign w_rptrNxt = w_pop  ? r_rptr + 1'b1 : r_rptr;
  assign w_wptrNxt = w_push ? r_wptr + 1'b1 : r_wptr;

  // Head register holds the entry at the next read pointer; the
  // incoming record is bypassed when it lands in that very slot.
  // An empty FIFO keeps the last head visible.
  always_comb begin
    w_headNxt = r_head;
    if (w_rptrNxt != w_wptrNxt) begin
      if (w_push && (w_rptrNxt[AW-1:0] == r_wptr[AW-1:0]))
        w_headNxt = w_rec;
      else
        w_headNxt = r_mem[w_rptrNxt[AW-1:0]];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_head        <= '0;
      r_prevVector  <= '0;
      r_prevWarning <= '0;
      r_ts          <= '0;
      r_overflow    <= 1'b0;
      r_ovfCount    <= '0;
    end else begin
      r_prevVector  <= abnormalityVector;
      r_prevWarning <= abnormalityWarning;
      r_ts          <= r_ts + 1'b1;
      if (w_push)
        r_mem[r_wptr[AW-1:0]] <= w_rec;
      r_wptr <= w_wptrNxt;
      r_rptr <= w_rptrNxt;
      r_head <= w_headNxt;
      if (clearOverflow) begin
        r_overflow <= 1'b0;
        r_ovfCount <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_ovfCount != 8'hFF)
          r_ovfCount <= r_ovfCount + 1'b1;
      end
    end
  end

  assign evt.eventValid     = !w_empty;
  assign evt.eventTimestamp = r_head[RW-1:9];
  assign evt.eventWarning   = r_head[8:6];
  assign evt.eventVector    = r_head[5:0];
  assign eventCount         = r_wptr - r_rptr;
  assign overflow           = r_overflow;
  assign overflowCount      = r_ovfCount;
endmodule

// File: tb/tb_abnormality_event_logger.sv
// Randomised and directed bench for abnormality_event_logger.
// Queue-based reference model; outputs sampled 1ns after each rising edge.
module tb_abnormality_event_logger;
  localparam int DEPTH = 8;
  localparam int TSW   = 8;

  logic       clock  = 1'b0;
  logic       resetN = 1'b0;
  logic [5:0] vec    = '0;
  logic [2:0] warn   = '0;
  logic       clr    = 1'b0;
  logic [3:0] cnt;
  logic       ovf;
  logic [7:0] ovc;

  abnormality_event_logger_if #(.TS_WIDTH(TSW)) evt ();

  abnormality_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clock              (clock),
    .resetN             (resetN),
    .abnormalityVector  (vec),
    .abnormalityWarning (warn),
    .clearOverflow      (clr),
    .evt                (evt),
    .eventCount         (cnt),
    .overflow           (ovf),
    .overflowCount      (ovc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] ts;
    logic [2:0] w;
    logic [5:0] v;
  } rec_t;

  rec_t       q[$];
  rec_t       m_head = '0;
  logic [5:0] m_pv   = '0;
  logic [2:0] m_pw   = '0;
  logic [7:0] m_ts   = '0;
  logic       m_ovf  = 1'b0;
  logic [7:0] m_ovc  = '0;
  int         total  = 0;
  int         bad    = 0;

  function automatic logic [30:0] exp_bus();
    logic v;
    v = (q.size() != 0);
    return {v, m_head, 4'(q.size()), m_ovf, m_ovc};
  endfunction

  function automatic logic [30:0] dut_bus();
    return {evt.eventValid, evt.eventTimestamp, evt.eventWarning,
            evt.eventVector, cnt, ovf, ovc};
  endfunction

  task automatic drive(input logic [5:0] v, input logic [2:0] w,
                       input logic rdy, input logic c);
    logic trig, pop, full, drop;
    vec = v;
    warn = w;
    evt.eventReady = rdy;
    clr = c;
    trig = ((v & ~m_pv) != 0) || (w > m_pw);
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == DEPTH);
    drop = 1'b0;
    if (pop) void'(q.pop_front());
    if (trig) begin
      if (!full || pop) q.push_back('{ts: m_ts, w: w, v: v});
      else drop = 1'b1;
    end
    if (c) begin
      m_ovf = 1'b0;
      m_ovc = '0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_ovc != 8'd255) m_ovc = m_ovc + 8'd1;
    end
    m_pv = v;
    m_pw = w;
    m_ts = m_ts + 8'd1;
    if (q.size() > 0) m_head = q[0];
    @(posedge clock);
    #1;
  endtask

  task automatic assert_reset();
    resetN = 1'b0;
    q.delete();
    m_head = '0;
    m_pv = '0;
    m_pw = '0;
    m_ts = '0;
    m_ovf = 1'b0;
    m_ovc = '0;
    #2;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    evt.eventReady = 1'b0;
    assert_reset();
    total++;
    if (dut_bus() !== 31'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", dut_bus());
    end
    release_reset();
  endtask

  task automatic test_first_event();
    while (m_ts != 8'd5) drive(6'd0, 3'd0, 1'b0, 1'b0);
    drive(6'b100000, 3'd0, 1'b0, 1'b0);
    total++;
    if ({evt.eventValid, evt.eventVector, evt.eventTimestamp,
         evt.eventWarning, cnt} !== {1'b1, 6'b100000, 8'd5, 3'd0, 4'd1}) begin
      bad++;
      $display("FAIL first_event: got v=%b vec=%b ts=%0d w=%0d c=%0d",
               evt.eventValid, evt.eventVector, evt.eventTimestamp,
               evt.eventWarning, cnt);
    end
    total++;
    if (dut_bus() !== exp_bus()) begin
      bad++;
      $display("FAIL first_event_model: got %h want %h", dut_bus(), exp_bus());
    end
  endtask

  task automatic test_warning();
    drive(6'b100000, 3'd1, 1'b1, 1'b0);
    drive(6'b100000, 3'd1, 1'b1, 1'b0);
    drive(6'b100000, 3'd3, 1'b0, 1'b0);
    drive(6'b100000, 3'd2, 1'b0, 1'b0);
    drive(6'b100000, 3'd2, 1'b0, 1'b0);
    total++;
    if ({evt.eventValid, cnt, evt.eventWarning} !== {1'b1, 4'd1, 3'd3}) begin
      bad++;
      $display("FAIL warning_escalate: got v=%b c=%0d w=%0d want 1 1 3",
               evt.eventValid, cnt, evt.eventWarning);
    end
    drive(6'b100000, 3'd2, 1'b1, 1'b0);
    total++;
    if ({evt.eventValid, evt.eventWarning} !== {1'b0, 3'd3}) begin
      bad++;
      $display("FAIL empty_hold: got v=%b w=%0d want 0 3",
               evt.eventValid, evt.eventWarning);
    end
    total++;
    if (dut_bus() !== exp_bus()) begin
      bad++;
      $display("FAIL warning_model: got %h want %h", dut_bus(), exp_bus());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] saved [10];
    logic [5:0] v;
    assert_reset();
    vec = '0;
    release_reset();
    for (int i = 0; i < 10; i++) begin
      v = (i % 2 == 1) ? 6'd2 : 6'd1;
      saved[i] = m_ts;
      drive(v, 3'd0, 1'b0, 1'b0);
    end
    total++;
    if ({cnt, ovf, ovc} !== {4'd8, 1'b1, 8'd2}) begin
      bad++;
      $display("FAIL overflow_state: got c=%0d o=%b oc=%0d want 8 1 2",
               cnt, ovf, ovc);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (evt.eventTimestamp !== saved[i] || evt.eventValid !== 1'b1) begin
        bad++;
        $display("FAIL drain_order[%0d]: got ts=%0d v=%b want ts=%0d",
                 i, evt.eventTimestamp, evt.eventValid, saved[i]);
      end
      drive(v, 3'd0, 1'b1, 1'b0);
    end
    total++;
    if (dut_bus() !== exp_bus()) begin
      bad++;
      $display("FAIL drain_end: got %h want %h", dut_bus(), exp_bus());
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] newts;
    logic [5:0] v;
    assert_reset();
    vec = '0;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 1) ? 6'd2 : 6'd1;
      drive(v, 3'd0, 1'b0, 1'b0);
    end
    newts = m_ts;
    drive(6'd1, 3'd0, 1'b1, 1'b0);
    total++;
    if ({cnt, ovf, ovc} !== {4'd8, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL full_pop: got c=%0d o=%b oc=%0d want 8 0 0",
               cnt, ovf, ovc);
    end
    for (int i = 0; i < 7; i++) drive(6'd1, 3'd0, 1'b1, 1'b0);
    total++;
    if ({cnt, evt.eventTimestamp} !== {4'd1, newts}) begin
      bad++;
      $display("FAIL full_pop_last: got c=%0d ts=%0d want 1 %0d",
               cnt, evt.eventTimestamp, newts);
    end
    drive(6'd1, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    assert_reset();
    vec = '0;
    release_reset();
    for (int i = 0; i < 8 + 300; i++)
      drive((i % 2 == 1) ? 6'd2 : 6'd1, 3'd0, 1'b0, 1'b0);
    total++;
    if ({ovf, ovc} !== {1'b1, 8'd255}) begin
      bad++;
      $display("FAIL saturate: got o=%b oc=%0d want 1 255", ovf, ovc);
    end
    drive(6'd1, 3'd0, 1'b0, 1'b1);
    total++;
    if ({ovf, ovc, cnt} !== {1'b0, 8'd0, 4'd8}) begin
      bad++;
      $display("FAIL clear_wins: got o=%b oc=%0d c=%0d want 0 0 8",
               ovf, ovc, cnt);
    end
  endtask

  task automatic test_random();
    logic [5:0] v;
    logic [2:0] w;
    logic       r;
    logic       c;
    int         errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      v = 6'($urandom_range(0, 63));
      w = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 31) == 0);
      drive(v, w, r, c);
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL random[%0d]: got %h want %h", i, dut_bus(), exp_bus());
      end
    end
  endtask

  task automatic test_reset_mid();
    assert_reset();
    vec = '0;
    release_reset();
    drive(6'd1, 3'd0, 1'b0, 1'b0);
    drive(6'd2, 3'd0, 1'b0, 1'b0);
    drive(6'd3, 3'd0, 1'b0, 1'b0);
    total++;
    if (cnt !== 4'd3) begin
      bad++;
      $display("FAIL mid_queued: got c=%0d want 3", cnt);
    end
    assert_reset();
    total++;
    if (dut_bus() !== 31'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h want 0", dut_bus());
    end
    release_reset();
    drive(6'd3, 3'd0, 1'b0, 1'b0);
    total++;
    if ({evt.eventValid, evt.eventVector, evt.eventTimestamp, cnt} !==
        {1'b1, 6'b000011, 8'd0, 4'd1}) begin
      bad++;
      $display("FAIL reset_retrigger: got v=%b vec=%b ts=%0d c=%0d",
               evt.eventValid, evt.eventVector, evt.eventTimestamp, cnt);
    end
  endtask

  initial begin
    evt.eventReady = 1'b0;
    #1;
    test_reset();
    test_first_event();
    test_warning();
    test_overflow();
    test_full_pop();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
